// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and defaults for the NES CPU-clock PLL lock sequencer.
// Holds the state encoding, default timing constants and the counter-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } pll_seq_state_t;

  // Defaults assume a 50 MHz reference clock.
  localparam int DEF_RST_HOLD_CYCLES     = 500;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 5_000_000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  // One shared counter covers every timed state, so size it for the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Both stages clear to 0 on reset so an unknown input reads as deasserted.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the CPU-clock PLL: reset hold, lock wait,
// stable-lock window, then release of the downstream reset; faults after repeated failures.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

  logic             locked_s;
  pll_seq_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RTY_W-1:0] retry_reg, retry_next;
  logic             attempt_failed;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_next     = state_reg;
    retry_next     = retry_reg;
    cnt_next       = cnt_reg;
    attempt_failed = 1'b0;

    case (state_reg)
      RESET_HOLD: begin
        if (cnt_reg == HOLD_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)                  state_next     = STABILIZE;
        else if (cnt_reg == TMO_LAST)  attempt_failed = 1'b1;
      end
      STABILIZE: begin
        if (!locked_s)                 attempt_failed = 1'b1;
        else if (cnt_reg == STB_LAST)  state_next     = RUN;
      end
      RUN: begin
        // Losing lock after a good sequence starts over rather than counting as a retry.
        if (!locked_s) begin
          state_next = RESET_HOLD;
          retry_next = '0;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RESET_HOLD;
        retry_next = '0;
      end
    endcase

    if (attempt_failed) begin
      if (retry_reg == RTY_MAX) begin
        state_next = FAULT;
      end else begin
        state_next = RESET_HOLD;
        retry_next = retry_reg + 1'b1;
      end
    end

    // Software restart overrides whatever else happened this cycle.
    if (relock_req) begin
      state_next = RESET_HOLD;
      retry_next = '0;
    end

    // A relock in RESET_HOLD is a re-entry, so it restarts the hold interval too.
    if (relock_req || (state_next != state_reg)) begin
      cnt_next = '0;
    end else if (cnt_reg != '1) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_HOLD;
      cnt_reg   <= '0;
      retry_reg <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      // Outputs decode the next state so they switch on the same edge as the state.
      pll_rst   <= (state_next == RESET_HOLD) || (state_next == FAULT);
      sys_rst_n <= (state_next == RUN);
      ready     <= (state_next == RUN);
      fault     <= (state_next == FAULT);
    end
  end

  assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer using small timing parameters.
// Output vector order: {pll_rst, sys_rst_n, ready, fault, retry_count[1:0]}.
module tb_pll_lock_sequencer;

  localparam int HOLD = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MR   = 2;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [1:0] retry_count;
  logic [5:0] obs;
  logic [5:0] exp_v;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  assign obs = {pll_rst, sys_rst_n, ready, fault, retry_count};

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES     (HOLD),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs, 6'b100000);
    end
    $display("test_reset: outputs %b", obs);
  endtask

  task automatic test_nominal;
    rst_n = 1'b1;
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL nominal_hold_edge3: got %b expected %b", obs, 6'b100000);
    end
    step(1);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL nominal_pll_rst_fall_edge4: got %b expected %b", obs, 6'b000000);
    end
    step(5);
    pll_locked = 1'b1;
    step(10);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL nominal_not_run_edge19: got %b expected %b", obs, 6'b000000);
    end
    step(1);
    checks++;
    if (obs !== 6'b011000) begin
      errors++; $display("FAIL nominal_run_edge20: got %b expected %b", obs, 6'b011000);
    end
    $display("test_nominal: outputs at edge 20 %b", obs);
  endtask

  task automatic test_lock_loss;
    pll_locked = 1'b0;
    step(2);
    checks++;
    if (obs !== 6'b011000) begin
      errors++; $display("FAIL lockloss_still_run_k2: got %b expected %b", obs, 6'b011000);
    end
    step(1);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL lockloss_drop_k3: got %b expected %b", obs, 6'b100000);
    end
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL lockloss_hold: got %b expected %b", obs, 6'b100000);
    end
    step(1);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL lockloss_wait: got %b expected %b", obs, 6'b000000);
    end
    pll_locked = 1'b1;
    step(10);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL lockloss_not_run: got %b expected %b", obs, 6'b000000);
    end
    step(1);
    checks++;
    if (obs !== 6'b011000) begin
      errors++; $display("FAIL lockloss_rerun: got %b expected %b", obs, 6'b011000);
    end
    $display("test_lock_loss: re-sequenced outputs %b", obs);
  endtask

  task automatic test_glitch;
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL glitch_relock_from_run: got %b expected %b", obs, 6'b100000);
    end
    step(4);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL glitch_wait: got %b expected %b", obs, 6'b000000);
    end
    step(2);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL glitch_before_fail: got %b expected %b", obs, 6'b000000);
    end
    step(1);
    checks++;
    if (obs !== 6'b100001) begin
      errors++; $display("FAIL glitch_fail_retry1: got %b expected %b", obs, 6'b100001);
    end
    step(4);
    checks++;
    if (obs !== 6'b000001) begin
      errors++; $display("FAIL glitch_wait2: got %b expected %b", obs, 6'b000001);
    end
    step(8);
    checks++;
    if (obs !== 6'b000001) begin
      errors++; $display("FAIL glitch_not_run: got %b expected %b", obs, 6'b000001);
    end
    step(1);
    checks++;
    if (obs !== 6'b011001) begin
      errors++; $display("FAIL glitch_run_retry1: got %b expected %b", obs, 6'b011001);
    end
    $display("test_glitch: outputs %b", obs);
  endtask

  task automatic test_timeout_fault;
    pll_locked = 1'b0;
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL timeout_lockloss_clear: got %b expected %b", obs, 6'b100000);
    end
    for (int att = 0; att <= MR; att++) begin
      exp_v = {4'b0000, 2'(att)};
      step(4);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout_wait_enter att%0d: got %b expected %b", att, obs, exp_v);
      end
      step(19);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout_wait_last att%0d: got %b expected %b", att, obs, exp_v);
      end
      step(1);
      exp_v = (att < MR) ? {4'b1000, 2'(att + 1)} : 6'b100110;
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL timeout_expire att%0d: got %b expected %b", att, obs, exp_v);
      end
      $display("test_timeout_fault: attempt %0d outputs %b", att, obs);
    end
    step(50);
    checks++;
    if (obs !== 6'b100110) begin
      errors++; $display("FAIL fault_sticky: got %b expected %b", obs, 6'b100110);
    end
  endtask

  task automatic test_relock_priority;
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL relock_from_fault: got %b expected %b", obs, 6'b100000);
    end
    step(24);
    checks++;
    if (obs !== 6'b100001) begin
      errors++; $display("FAIL relock_first_timeout: got %b expected %b", obs, 6'b100001);
    end
    step(23);
    checks++;
    if (obs !== 6'b000001) begin
      errors++; $display("FAIL relock_wait_last: got %b expected %b", obs, 6'b000001);
    end
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL relock_vs_timeout: got %b expected %b", obs, 6'b100000);
    end
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL relock_hold3: got %b expected %b", obs, 6'b100000);
    end
    step(1);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL relock_hold_release: got %b expected %b", obs, 6'b000000);
    end
    $display("test_relock_priority: outputs %b", obs);
  endtask

  task automatic test_async_reset;
    step(20);
    checks++;
    if (obs !== 6'b100001) begin
      errors++; $display("FAIL async_prep_timeout: got %b expected %b", obs, 6'b100001);
    end
    step(4);
    pll_locked = 1'b1;
    step(4);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL async_reset_immediate: got %b expected %b", obs, 6'b100000);
    end
    step(2);
    rst_n = 1'b1;
    step(3);
    checks++;
    if (obs !== 6'b100000) begin
      errors++; $display("FAIL async_rerelease_hold: got %b expected %b", obs, 6'b100000);
    end
    step(1);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL async_rerelease_wait: got %b expected %b", obs, 6'b000000);
    end
    step(8);
    checks++;
    if (obs !== 6'b000000) begin
      errors++; $display("FAIL async_not_run: got %b expected %b", obs, 6'b000000);
    end
    step(1);
    checks++;
    if (obs !== 6'b011000) begin
      errors++; $display("FAIL async_run: got %b expected %b", obs, 6'b011000);
    end
    $display("test_async_reset: outputs %b", obs);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_glitch();
    test_timeout_fault();
    test_relock_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
